// File: rtl/e_mul_div_unit_pkg.sv
// Shared opcodes, latency defaults, state/result types and the arithmetic
// helper for the execute-stage multiply/divide unit.
package e_mul_div_unit_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_result_t;

  // Signed divide is done on magnitudes so the 0x80000000 / -1 corner is
  // well defined (quotient wraps to 0x80000000, remainder 0).
  function automatic mdu_result_t mdu_compute(input logic [3:0]  op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    mdu_result_t res;
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo;
    logic [31:0] rem;
    res.wr = 1'b0;
    res.hi = 32'd0;
    res.lo = 32'd0;
    prod   = 64'd0;
    quo    = 32'd0;
    rem    = 32'd0;
    mag_a  = a[31] ? (32'd0 - a) : a;
    mag_b  = b[31] ? (32'd0 - b) : b;
    case (op)
      MDU_MULT: begin
        prod   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        res.wr = 1'b1;
        res.hi = prod[63:32];
        res.lo = prod[31:0];
      end
      MDU_MULTU: begin
        prod   = {32'd0, a} * {32'd0, b};
        res.wr = 1'b1;
        res.hi = prod[63:32];
        res.lo = prod[31:0];
      end
      MDU_DIV: begin
        if (b != 32'd0) begin
          quo    = mag_a / mag_b;
          rem    = mag_a % mag_b;
          res.wr = 1'b1;
          res.lo = (a[31] ^ b[31]) ? (32'd0 - quo) : quo;
          res.hi = a[31] ? (32'd0 - rem) : rem;
        end else begin
          res.wr = 1'b0;
        end
      end
      MDU_DIVU: begin
        if (b != 32'd0) begin
          res.wr = 1'b1;
          res.lo = a / b;
          res.hi = a % b;
        end else begin
          res.wr = 1'b0;
        end
      end
      default: res.wr = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/e_mul_div_unit.sv
// Execute-stage multiply/divide unit: sole owner of HI/LO. Results are
// computed at start and held back until the latency counter expires.
module e_mul_div_unit
  import e_mul_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data
);

  localparam logic [31:0] MULT_N = 32'(MULT_CYCLES);
  localparam logic [31:0] DIV_N  = 32'(DIV_CYCLES);

  mdu_state_e  state_q, state_d;
  logic        busy_q, busy_d;
  logic [31:0] cnt_q, cnt_d;
  mdu_result_t pend_q, pend_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Next-state: start/MT* accepted only in IDLE, commit on counter expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        case (md_op)
          MDU_MULT, MDU_MULTU: begin
            pend_d  = mdu_compute(md_op, md_a, md_b);
            cnt_d   = MULT_N;
            state_d = ST_RUN;
          end
          MDU_DIV, MDU_DIVU: begin
            pend_d  = mdu_compute(md_op, md_a, md_b);
            cnt_d   = DIV_N;
            state_d = ST_RUN;
          end
          MDU_MTHI: hi_d = md_a;
          MDU_MTLO: lo_d = md_a;
          default:  state_d = ST_IDLE;
        endcase
      end
      ST_RUN: begin
        if (cnt_q <= 32'd1) begin
          cnt_d   = 32'd0;
          state_d = ST_IDLE;
          if (pend_q.wr) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          cnt_d   = cnt_q - 32'd1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // State and architectural registers; reset discards any in-flight result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= 32'd0;
      pend_q  <= mdu_result_t'(65'd0);
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Move-from read port; returns committed values only.
  always_comb begin
    case (md_op)
      MDU_MFHI: mf_data = hi_q;
      MDU_MFLO: mf_data = lo_q;
      default:  mf_data = 32'd0;
    endcase
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
